// File: rtl/amba_ahb_lite_burst_scheduler.sv
// AHB-lite grant scheduler for a shared slave port.
// Picks one owner per address phase and drives HMASTER to the output-stage muxes.
// Fixed-length bursts and locked sequences are never split. Undefined-length INCR
// ownership is capped while other masters are waiting.
//
// Handshake: HREADY=1 means the current address phase is accepted, and every
// state, grant and counter update happens only on such an edge. HREADY=0 freezes
// everything. An owner beat counts as "accepted" when HREADY=1 and the owner's
// HTRANS is NONSEQ or SEQ. The owner is always the master in out_HMASTER.
module amba_ahb_lite_burst_scheduler #(
  parameter int N_MASTER        = 2,
  parameter int W_MASTER        = 1,
  parameter int NUM_DEF_MASTER  = 0,
  parameter int PRIORITY_SCHEME = 1,
  parameter int MAX_INCR_BEATS  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [N_MASTER-1:0]   ma_bus_req,
  input  logic [N_MASTER*2-1:0] ma_HTRANS,
  input  logic [N_MASTER*3-1:0] ma_HBURST,
  input  logic [N_MASTER-1:0]   ma_HMASTLOCK,
  input  logic                  HREADY,
  output logic [N_MASTER-1:0]   out_ma_active,
  output logic [W_MASTER-1:0]   out_HMASTER,
  output logic                  out_trans,
  output logic [1:0]            q_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  // What the owner's current cycle asks the scheduler to do.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ARB,
    ACT_ARBX,
    ACT_LOCK,
    ACT_BURST,
    ACT_INCR_START,
    ACT_INCR_STEP,
    ACT_BEAT
  } act_e;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;

  state_e              state_q;
  logic [W_MASTER-1:0] hmaster_q;
  logic [W_MASTER-1:0] rr_ptr_q;
  logic [3:0]          beat_cnt_q;
  logic [7:0]          incr_cnt_q;

  // Owner-side view of the request inputs.
  logic [1:0]          own_trans;
  logic [2:0]          own_burst;
  logic                own_lock;
  logic                own_req;
  logic [N_MASTER-1:0] own_oh;
  logic                others_req;

  assign own_trans  = ma_HTRANS[int'(hmaster_q)*2 +: 2];
  assign own_burst  = ma_HBURST[int'(hmaster_q)*3 +: 3];
  assign own_lock   = ma_HMASTLOCK[hmaster_q];
  assign own_req    = ma_bus_req[hmaster_q];
  assign own_oh     = {{(N_MASTER-1){1'b0}}, 1'b1} << hmaster_q;
  assign others_req = |(ma_bus_req & ~own_oh);

  // Returns {found, winner}. Fixed: lowest index. Round-robin: first set bit
  // searching upward from ptr+1 with wrap.
  function automatic logic [W_MASTER:0] arb_pick(input logic [N_MASTER-1:0] req,
                                                 input logic [W_MASTER-1:0] ptr);
    logic                found;
    logic [W_MASTER-1:0] win;
    int                  idx;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_MASTER; k++) begin
      if (PRIORITY_SCHEME == 0) begin
        idx = k - 1;
      end else begin
        idx = int'(ptr) + k;
        if (idx >= N_MASTER) idx = idx - N_MASTER;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = W_MASTER'(idx);
      end
    end
    return {found, win};
  endfunction

  logic [W_MASTER:0] pick_all;
  logic [W_MASTER:0] pick_excl;

  assign pick_all  = arb_pick(ma_bus_req, rr_ptr_q);
  assign pick_excl = arb_pick(ma_bus_req & ~own_oh, rr_ptr_q);

  logic [3:0] len_m1;
  logic [7:0] incr_next;
  logic       incr_cap;

  // Beats remaining after the NONSEQ of a fixed-length burst.
  always_comb begin
    len_m1 = 4'd15;
    case (own_burst)
      3'd2, 3'd3: len_m1 = 4'd3;
      3'd4, 3'd5: len_m1 = 4'd7;
      default:    len_m1 = 4'd15;
    endcase
  end

  assign incr_next = (incr_cnt_q == 8'hFF) ? 8'hFF : incr_cnt_q + 8'd1;
  assign incr_cap  = (incr_next >= 8'(MAX_INCR_BEATS));

  act_e own_act;
  act_e act;

  // Rules for an owner that is not inside a fixed burst or a lock. This also
  // covers a NONSEQ inside a burst and the cycle that leaves a lock.
  always_comb begin
    own_act = ACT_HOLD;
    if (own_trans == TR_IDLE || !own_req) begin
      own_act = ACT_ARB;
    end else if (own_trans == TR_NONSEQ) begin
      if (own_lock)                    own_act = ACT_LOCK;
      else if (own_burst == HB_SINGLE) own_act = ACT_ARB;
      else if (own_burst == HB_INCR)   own_act = ACT_INCR_START;
      else                             own_act = ACT_BURST;
    end else if (own_trans == TR_SEQ) begin
      own_act = (incr_cap && others_req) ? ACT_ARBX : ACT_INCR_STEP;
    end
  end

  // Per-state choice of what happens on the next accepted edge.
  always_comb begin
    act = ACT_HOLD;
    case (state_q)
      ST_IDLE: act = ACT_ARB;
      ST_OWN:  act = own_act;
      ST_BURST: begin
        case (own_trans)
          TR_IDLE:   act = ACT_ARB;
          TR_BUSY:   act = ACT_HOLD;
          TR_NONSEQ: act = own_act;
          default:   act = (beat_cnt_q <= 4'd1) ? ACT_ARB : ACT_BEAT;
        endcase
      end
      ST_LOCK: begin
        if (!own_lock && own_trans != TR_BUSY) act = own_act;
        else                                   act = ACT_HOLD;
      end
      default: act = ACT_HOLD;
    endcase
  end

  // Scheduler FSM: state, owner, round-robin pointer and beat counters.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      hmaster_q  <= W_MASTER'(NUM_DEF_MASTER);
      rr_ptr_q   <= W_MASTER'(N_MASTER - 1);
      beat_cnt_q <= 4'd0;
      incr_cnt_q <= 8'd0;
    end else if (HREADY) begin
      case (act)
        ACT_ARB: begin
          beat_cnt_q <= 4'd0;
          incr_cnt_q <= 8'd0;
          if (pick_all[W_MASTER]) begin
            hmaster_q <= pick_all[W_MASTER-1:0];
            rr_ptr_q  <= pick_all[W_MASTER-1:0];
            state_q   <= ST_OWN;
          end else begin
            hmaster_q <= W_MASTER'(NUM_DEF_MASTER);
            state_q   <= ST_IDLE;
          end
        end
        ACT_ARBX: begin
          beat_cnt_q <= 4'd0;
          incr_cnt_q <= 8'd0;
          hmaster_q  <= pick_excl[W_MASTER-1:0];
          rr_ptr_q   <= pick_excl[W_MASTER-1:0];
          state_q    <= ST_OWN;
        end
        ACT_LOCK: begin
          state_q <= ST_LOCK;
        end
        ACT_BURST: begin
          beat_cnt_q <= len_m1;
          state_q    <= ST_BURST;
        end
        ACT_INCR_START: begin
          incr_cnt_q <= 8'd1;
          state_q    <= ST_OWN;
        end
        ACT_INCR_STEP: begin
          incr_cnt_q <= incr_next;
          state_q    <= ST_OWN;
        end
        ACT_BEAT: begin
          beat_cnt_q <= beat_cnt_q - 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_HMASTER   = hmaster_q;
  assign out_trans     = (state_q != ST_IDLE);
  assign out_ma_active = out_trans ? own_oh : '0;
  assign q_state       = state_q;

endmodule

// File: tb/tb_amba_ahb_lite_burst_scheduler.sv
// Bench for amba_ahb_lite_burst_scheduler: directed scenarios, a transaction-level
// ownership model, and a per-cycle compare against that model.
module tb_amba_ahb_lite_burst_scheduler;

  localparam int N    = 2;
  localparam int W    = 1;
  localparam int DEF  = 0;
  localparam int MAXB = 4;

  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] BSY = 2'd1;
  localparam logic [1:0] NSQ = 2'd2;
  localparam logic [1:0] SQ  = 2'd3;
  localparam logic [2:0] SGL = 3'd0;
  localparam logic [2:0] INC = 3'd1;
  localparam logic [2:0] I4  = 3'd3;
  localparam logic [2:0] W8  = 3'd4;
  localparam logic [2:0] I8  = 3'd5;

  // ---------------- clock / reset ----------------
  logic           HCLK = 1'b0;
  logic           HRESET = 1'b1;
  logic [N-1:0]   ma_bus_req = '0;
  logic [N*2-1:0] ma_HTRANS = '0;
  logic [N*3-1:0] ma_HBURST = '0;
  logic [N-1:0]   ma_HMASTLOCK = '0;
  logic           HREADY = 1'b1;
  logic [N-1:0]   out_ma_active;
  logic [W-1:0]   out_HMASTER;
  logic           out_trans;
  logic [1:0]     q_state;

  always #5 HCLK = ~HCLK;

  amba_ahb_lite_burst_scheduler #(
    .N_MASTER(N), .W_MASTER(W), .NUM_DEF_MASTER(DEF),
    .PRIORITY_SCHEME(1), .MAX_INCR_BEATS(MAXB)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .ma_bus_req(ma_bus_req), .ma_HTRANS(ma_HTRANS),
    .ma_HBURST(ma_HBURST), .ma_HMASTLOCK(ma_HMASTLOCK), .HREADY(HREADY),
    .out_ma_active(out_ma_active), .out_HMASTER(out_HMASTER),
    .out_trans(out_trans), .q_state(q_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // ---------------- ownership model ----------------
  // owner -1 = parked; mode 0 idle, 1 owned, 2 fixed burst, 3 locked.
  int m_owner;
  int m_mode;
  int m_last;
  int m_left;
  int m_incr;

  function automatic int m_pick(input logic [N-1:0] req, input int excl);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic m_arb(input int excl);
    int w;
    w = m_pick(ma_bus_req, excl);
    if (w < 0) begin
      m_owner = -1;
      m_mode  = 0;
    end else begin
      m_owner = w;
      m_last  = w;
      m_mode  = 1;
    end
    m_left = 0;
    m_incr = 0;
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_mode  = 0;
    m_last  = N - 1;
    m_left  = 0;
    m_incr  = 0;
  endtask

  task automatic m_step();
    int t, b;
    bit lk, rq;
    logic [N-1:0] oh;
    if (m_mode == 0) begin
      m_arb(-1);
      return;
    end
    t  = int'(ma_HTRANS[m_owner*2 +: 2]);
    b  = int'(ma_HBURST[m_owner*3 +: 3]);
    lk = ma_HMASTLOCK[m_owner];
    rq = ma_bus_req[m_owner];
    if (m_mode == 3) begin
      if (lk || t == 1) return;
    end else if (m_mode == 2) begin
      if (t == 0) begin m_arb(-1); return; end
      if (t == 1) return;
      if (t == 3) begin
        m_left = m_left - 1;
        if (m_left <= 0) m_arb(-1);
        return;
      end
    end
    if (t == 0 || !rq) begin
      m_arb(-1);
    end else if (t == 2) begin
      if (lk) m_mode = 3;
      else if (b >= 2) begin
        m_mode = 2;
        m_left = (4 << ((b - 2) / 2)) - 1;
      end else if (b == 0) m_arb(-1);
      else begin
        m_mode = 1;
        m_incr = 1;
      end
    end else if (t == 3) begin
      m_mode = 1;
      if (m_incr < 255) m_incr = m_incr + 1;
      oh = '0;
      oh[m_owner] = 1'b1;
      if (m_incr >= MAXB && (ma_bus_req & ~oh) != '0) m_arb(m_owner);
    end
  endtask

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) m_reset();
    else if (HREADY) m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge HCLK) begin
    if (cmp_en) begin
      logic [W-1:0] e_hm;
      logic [N-1:0] e_act;
      logic [1:0]   e_st;
      e_hm  = (m_owner < 0) ? W'(DEF) : W'(m_owner);
      e_st  = 2'(m_mode);
      e_act = '0;
      if (m_mode != 0) e_act[m_owner] = 1'b1;
      n_cmp++;
      if (out_HMASTER !== e_hm || q_state !== e_st || out_ma_active !== e_act ||
          out_trans !== (m_mode != 0)) begin
        n_err++;
        $display("FAIL cycle @%0t: got hm=%0d st=%0d act=%b trans=%b, model hm=%0d st=%0d act=%b",
                 $time, out_HMASTER, q_state, out_ma_active, out_trans, e_hm, e_st, e_act);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic cyc(input logic [1:0] req, input logic [1:0] t0, input logic [2:0] b0,
                     input logic [1:0] t1, input logic [2:0] b1,
                     input logic [1:0] lk, input logic rdy);
    ma_bus_req   = req;
    ma_HTRANS    = {t1, t0};
    ma_HBURST    = {b1, b0};
    ma_HMASTLOCK = lk;
    HREADY       = rdy;
    @(posedge HCLK);
    #1;
  endtask

  task automatic expect_st(input string nm, input int hm, input int st);
    logic [N-1:0] ea;
    ea = '0;
    if (st != 0) ea[hm] = 1'b1;
    n_cmp++;
    if (out_HMASTER !== W'(hm) || q_state !== 2'(st) || out_ma_active !== ea ||
        out_trans !== (st != 0)) begin
      n_err++;
      $display("FAIL %s: got hm=%0d st=%0d act=%b trans=%b, want hm=%0d st=%0d act=%b",
               nm, out_HMASTER, q_state, out_ma_active, out_trans, hm, st, ea);
    end
  endtask

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    cmp_en = 1'b1;
    expect_st("reset", 0, 0);

    // 1: round-robin fairness with SINGLE transfers
    cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b00, 1'b1); expect_st("rr_g0", 0, 1);
    cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b00, 1'b1); expect_st("rr_g1", 1, 1);
    cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b00, 1'b1); expect_st("rr_g2", 0, 1);
    cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b00, 1'b1); expect_st("rr_g3", 1, 1);
    cyc(2'b00, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("rr_park", 0, 0);

    // 2: INCR8 held for 8 beats, m1 waiting from beat 2
    cyc(2'b01, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("b8_grant", 0, 1);
    cyc(2'b01, NSQ, I8, IDL, SGL, 2'b00, 1'b1);  expect_st("b8_beat1", 0, 2);
    for (int i = 2; i <= 7; i++) begin
      cyc(2'b11, SQ, I8, NSQ, SGL, 2'b00, 1'b1);
      expect_st("b8_hold", 0, 2);
    end
    cyc(2'b11, SQ, I8, NSQ, SGL, 2'b00, 1'b1);   expect_st("b8_handover", 1, 1);
    cyc(2'b00, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("b8_park", 0, 0);

    // 3: wait states freeze grant and beat count
    cyc(2'b01, IDL, SGL, IDL, SGL, 2'b00, 1'b0); expect_st("ws_idle_frozen", 0, 0);
    cyc(2'b01, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("ws_grant", 0, 1);
    cyc(2'b01, NSQ, I4, IDL, SGL, 2'b00, 1'b1);  expect_st("ws_beat1", 0, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, SQ, I4, NSQ, SGL, 2'b00, 1'b0);
      expect_st("ws_wait", 0, 2);
    end
    cyc(2'b11, SQ, I4, NSQ, SGL, 2'b00, 1'b1);   expect_st("ws_beat2", 0, 2);
    cyc(2'b11, SQ, I4, NSQ, SGL, 2'b00, 1'b1);   expect_st("ws_beat3", 0, 2);
    cyc(2'b11, SQ, I4, NSQ, SGL, 2'b00, 1'b1);   expect_st("ws_handover", 1, 1);
    cyc(2'b00, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("ws_park", 0, 0);

    // 4: locked sequence from m1, m0 waits for the unlocked transfer
    cyc(2'b10, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("lk_grant", 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b10, 1'b1);
      expect_st("lk_locked", 1, 3);
    end
    cyc(2'b01, NSQ, SGL, IDL, SGL, 2'b10, 1'b1); expect_st("lk_reqdrop", 1, 3);
    cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b00, 1'b1); expect_st("lk_release", 0, 1);
    cyc(2'b00, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("lk_park", 0, 0);

    // 5: undefined INCR capped at 4 beats under contention, unlimited when alone
    cyc(2'b01, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("ic_grant", 0, 1);
    cyc(2'b11, NSQ, INC, NSQ, SGL, 2'b00, 1'b1); expect_st("ic_beat1", 0, 1);
    cyc(2'b11, SQ, INC, NSQ, SGL, 2'b00, 1'b1);  expect_st("ic_beat2", 0, 1);
    cyc(2'b11, SQ, INC, NSQ, SGL, 2'b00, 1'b1);  expect_st("ic_beat3", 0, 1);
    cyc(2'b11, SQ, INC, NSQ, SGL, 2'b00, 1'b1);  expect_st("ic_cap", 1, 1);
    cyc(2'b11, NSQ, INC, NSQ, SGL, 2'b00, 1'b1); expect_st("ic_back", 0, 1);
    cyc(2'b01, NSQ, INC, IDL, SGL, 2'b00, 1'b1); expect_st("ic_alone1", 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(2'b01, SQ, INC, IDL, SGL, 2'b00, 1'b1);
      expect_st("ic_alone", 0, 1);
    end
    cyc(2'b00, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("ic_park", 0, 0);

    // 6: asynchronous reset during WRAP8 beat 3
    cyc(2'b10, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("rs_grant", 1, 1);
    cyc(2'b10, IDL, SGL, NSQ, W8, 2'b00, 1'b1);  expect_st("rs_beat1", 1, 2);
    cyc(2'b10, IDL, SGL, SQ, W8, 2'b00, 1'b1);   expect_st("rs_beat2", 1, 2);
    ma_HTRANS = {SQ, IDL};
    #2;
    HRESET = 1'b1;
    #1;
    expect_st("rs_async", 0, 0);
    @(posedge HCLK);
    #1;
    expect_st("rs_edge", 0, 0);
    HRESET = 1'b0;
    cyc(2'b11, NSQ, SGL, NSQ, SGL, 2'b00, 1'b1); expect_st("rs_rrptr", 0, 1);
    cyc(2'b00, IDL, SGL, IDL, SGL, 2'b00, 1'b1); expect_st("rs_park", 0, 0);

    @(posedge HCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
